// File: rtl/aes_key_schedule_pkg.sv
// Shared types and tables for the sequential AES-128 key schedule.
// Holds the FSM state enum, the key word layout, the S-box and the round constants.
package aes_key_schedule_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_WORD_W = 32;
  localparam int KEY_WORDS  = 4;

  typedef logic [KEY_WORDS-1:0][KEY_WORD_W-1:0] key_t;

  typedef enum logic {KS_IDLE, KS_EXPAND} ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for rounds 1..10; anything else contributes nothing.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion.sv
// One combinational AES-128 key expansion step: previous round key plus round index in,
// next round key out. Word 0 is the first word of the key.
module key_expansion
  import aes_key_schedule_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] key_i,
  input  logic [vecSize-1:0][regSize-1:0] round_i,
  output logic [vecSize-1:0][regSize-1:0] key_o
);

  logic [regSize-1:0] rot_w;
  logic [regSize-1:0] sub_w;
  logic [regSize-1:0] mix_w;
  logic               unused_round_bits;

  // The round index is replicated across every word; only the low bits of word 0 matter.
  assign unused_round_bits = ^{round_i[vecSize-1:1], round_i[0][regSize-1:4]};

  always_comb begin
    rot_w = {key_i[vecSize-1][regSize-9:0], key_i[vecSize-1][regSize-1:regSize-8]};
    sub_w = '0;
    for (int b = 0; b < regSize / 8; b++) begin
      sub_w[b*8 +: 8] = sbox(rot_w[b*8 +: 8]);
    end
    mix_w = sub_w ^ {rcon(round_i[0][3:0]), {(regSize-8){1'b0}}};
    key_o    = '0;
    key_o[0] = key_i[0] ^ mix_w;
    for (int i = 1; i < vecSize; i++) begin
      key_o[i] = key_i[i] ^ key_o[i-1];
    end
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one expansion step per clock fills a bank of
// NUM_ROUNDS+1 round keys that the round datapath reads by index.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = aes_key_schedule_pkg::NUM_ROUNDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  output logic                            busy,
  output logic                            done,
  output logic                            keys_valid,
  input  logic [3:0]                      rd_round,
  output logic [vecSize-1:0][regSize-1:0] rd_key,
  output logic                            rd_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t                       state_q;
  logic [3:0]                      round_cnt_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            keys_valid_q;
  logic [vecSize-1:0][regSize-1:0] bank_q [NUM_ROUNDS+1];

  logic [3:0]                      prev_idx;
  logic [vecSize-1:0][regSize-1:0] round_vec;
  logic [vecSize-1:0][regSize-1:0] bank_d;

  // In IDLE the counter is 0; clamp so the expansion input never indexes past the bank.
  assign prev_idx  = (round_cnt_q == 4'd0) ? 4'd0 : round_cnt_q - 4'd1;
  assign round_vec = {vecSize{{{(regSize-4){1'b0}}, round_cnt_q}}};

  key_expansion #(
    .regSize (regSize),
    .vecSize (vecSize)
  ) u_key_expansion (
    .key_i   (bank_q[prev_idx]),
    .round_i (round_vec),
    .key_o   (bank_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= KS_IDLE;
      round_cnt_q  <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int r = 0; r <= NUM_ROUNDS; r++) begin
        bank_q[r] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        KS_IDLE: begin
          if (start) begin
            bank_q[0]    <= key_in;
            round_cnt_q  <= 4'd1;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= KS_EXPAND;
          end
        end
        KS_EXPAND: begin
          bank_q[round_cnt_q] <= bank_d;
          if (round_cnt_q == LAST_ROUND) begin
            state_q      <= KS_IDLE;
            round_cnt_q  <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end else begin
            round_cnt_q <= round_cnt_q + 4'd1;
          end
        end
        default: state_q <= KS_IDLE;
      endcase
    end
  end

  // Reads are always live; validity is reported separately so partial banks are visible but flagged.
  always_comb begin
    rd_key = '0;
    if (rd_round <= LAST_ROUND) begin
      rd_key = bank_q[rd_round];
    end
  end

  assign rd_valid   = keys_valid_q && (rd_round <= LAST_ROUND);
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-array FIPS-197 model
// whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_schedule;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0][31:0]  key_in = '0;
  logic [3:0]        rd_round = 4'd0;
  logic              busy, done, keys_valid, rd_valid;
  logic [3:0][31:0]  rd_key;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]       sbox_m [256];
  logic [3:0][31:0] model_keys [11];

  aes_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [3:0][31:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [3:0][31:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [3:0][31:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = k[j];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 4; j++) model_keys[r][j] = w[4*r + j];
  endtask

  task automatic read_key(input int idx, output logic [3:0][31:0] k, output logic v);
    rd_round = 4'(idx);
    #1;
    k = rd_key;
    v = rd_valid;
  endtask

  // Starts a schedule and waits for done; optionally re-pulses start mid-run with another key.
  task automatic run_schedule(input logic [3:0][31:0] k, input int pulse_at,
                              input logic [3:0][31:0] k2, output int lat,
                              output int busy_bad, output logic busy_at_done);
    lat = 0; busy_bad = 0; busy_at_done = 1'bx;
    @(negedge clk);
    start = 1'b1; key_in = k;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; key_in = rand_key(); end
      if (cyc == pulse_at) begin start = 1'b1; key_in = k2; end
      if (pulse_at > 0 && cyc == pulse_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = cyc; busy_at_done = busy;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    logic [3:0][31:0] k; logic v;
    #2;
    n_cmp++; if ({busy, done, keys_valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl: got busy/done/kv=%b required 000", {busy, done, keys_valid}); end
    for (int r = 0; r <= 10; r += 10) begin
      read_key(r, k, v);
      n_cmp++; if (k !== '0 || v !== 1'b0) begin n_fail++;
        $display("FAIL reset_bank%0d: got key=%h valid=%b required 0/0", r, k, v); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_key();
    int lat, bb; logic bd; logic [3:0][31:0] k; logic v;
    run_schedule('0, 0, '0, lat, bb, bd);
    n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL zero_latency: got %0d required 11", lat); end
    n_cmp++; if (bb !== 0 || bd !== 1'b0) begin n_fail++;
      $display("FAIL zero_busy: got bad_cycles=%0d busy_at_done=%b required 0/0", bb, bd); end
    n_cmp++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL zero_kv: got %b required 1", keys_valid); end
    read_key(1, k, v);
    n_cmp++; if (k !== {4{32'h62636363}} || v !== 1'b1) begin n_fail++;
      $display("FAIL zero_r1: got %h valid=%b required %h/1", k, v, {4{32'h62636363}}); end
    read_key(10, k, v);
    n_cmp++; if (k !== mk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e)) begin n_fail++;
      $display("FAIL zero_r10: got %h", k); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b required 0", done); end
  endtask

  task automatic check_fips(input string tag);
    logic [3:0][31:0] k; logic v;
    read_key(10, k, v);
    n_cmp++; if (k !== mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6) || v !== 1'b1) begin
      n_fail++; $display("FAIL %s_r10: got %h valid=%b", tag, k, v); end
    read_key(1, k, v);
    n_cmp++; if (k !== mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605)) begin
      n_fail++; $display("FAIL %s_r1: got %h", tag, k); end
    for (int r = 0; r <= 10; r++) begin
      read_key(r, k, v);
      n_cmp++; if (k !== model_keys[r]) begin n_fail++;
        $display("FAIL %s_model_r%0d: got %h required %h", tag, r, k, model_keys[r]); end
    end
  endtask

  task automatic test_fips();
    int lat, bb; logic bd;
    logic [3:0][31:0] fk = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    model_expand(fk);
    run_schedule(fk, 0, '0, lat, bb, bd);
    n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL fips_latency: got %0d required 11", lat); end
    check_fips("fips");
  endtask

  task automatic test_start_ignored();
    int lat, bb; logic bd;
    logic [3:0][31:0] fk = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    model_expand(fk);
    run_schedule(fk, 4, rand_key(), lat, bb, bd);
    n_cmp++; if (lat !== 11 || bb !== 0) begin n_fail++;
      $display("FAIL ignore_latency: got lat=%0d bad_busy=%0d required 11/0", lat, bb); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_restart: got busy=%b required 0", busy); end
    check_fips("ignore");
  endtask

  task automatic test_reset_mid();
    int lat, bb; logic bd; logic [3:0][31:0] k; logic v;
    logic [3:0][31:0] nk = rand_key();
    @(negedge clk);
    start = 1'b1; key_in = rand_key();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, keys_valid} !== 3'b000) begin n_fail++;
      $display("FAIL midrst_ctrl: got busy/done/kv=%b required 000", {busy, done, keys_valid}); end
    for (int r = 0; r <= 10; r++) begin
      read_key(r, k, v);
      n_cmp++; if (k !== '0 || v !== 1'b0) begin n_fail++;
        $display("FAIL midrst_bank%0d: got %h valid=%b required 0/0", r, k, v); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_expand(nk);
    run_schedule(nk, 0, '0, lat, bb, bd);
    n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL midrst_latency: got %0d required 11", lat); end
    read_key(10, k, v);
    n_cmp++; if (k !== model_keys[10] || v !== 1'b1) begin n_fail++;
      $display("FAIL midrst_r10: got %h valid=%b required %h/1", k, v, model_keys[10]); end
  endtask

  task automatic test_read_range();
    logic [3:0][31:0] k; logic v;
    logic [3:0][31:0] rk = rand_key();
    int lat, bb; logic bd;
    run_schedule(rk, 0, '0, lat, bb, bd);
    read_key(11, k, v);
    n_cmp++; if (k !== '0 || v !== 1'b0) begin n_fail++; $display("FAIL range_r11: got %h valid=%b required 0/0", k, v); end
    read_key(15, k, v);
    n_cmp++; if (k !== '0 || v !== 1'b0) begin n_fail++; $display("FAIL range_r15: got %h valid=%b required 0/0", k, v); end
    read_key(0, k, v);
    n_cmp++; if (k !== rk || v !== 1'b1) begin n_fail++;
      $display("FAIL range_r0: got %h valid=%b required %h/1", k, v, rk); end
  endtask

  task automatic test_back_to_back();
    logic [3:0][31:0] ka = rand_key();
    logic [3:0][31:0] kb = rand_key();
    logic [3:0][31:0] a10, k; logic v;
    int d1 = 0, d2 = 0, kv_bad = 0, done_bad = 0, rv_bad = 0;
    model_expand(ka);
    a10 = model_keys[10];
    @(negedge clk);
    start = 1'b1; key_in = ka;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 5) key_in = kb;
      if (done === 1'b1) begin
        if (d1 == 0) begin
          d1 = cyc;
          read_key(10, k, v);
          n_cmp++; if (k !== a10 || v !== 1'b1) begin n_fail++;
            $display("FAIL b2b_first_r10: got %h valid=%b required %h/1", k, v, a10); end
        end else begin
          d2 = cyc; start = 1'b0;
          break;
        end
      end else if (d1 != 0) begin
        if (keys_valid !== 1'b0) kv_bad++;
        if (cyc == d1 + 1 && busy !== 1'b1) done_bad++;
        if (cyc == d1 + 4) begin read_key(3, k, v); if (v !== 1'b0) rv_bad++; end
      end
    end
    n_cmp++; if (d1 !== 11) begin n_fail++; $display("FAIL b2b_first_done: got %0d required 11", d1); end
    n_cmp++; if (d2 - d1 !== 11) begin n_fail++; $display("FAIL b2b_spacing: got %0d required 11", d2 - d1); end
    n_cmp++; if (kv_bad !== 0 || done_bad !== 0 || rv_bad !== 0) begin n_fail++;
      $display("FAIL b2b_between: got kv_bad=%0d restart_bad=%0d rdvalid_bad=%0d required 0", kv_bad, done_bad, rv_bad); end
    model_expand(kb);
    for (int r = 0; r <= 10; r++) begin
      read_key(r, k, v);
      n_cmp++; if (k !== model_keys[r]) begin n_fail++;
        $display("FAIL b2b_second_r%0d: got %h required %h", r, k, model_keys[r]); end
    end
  endtask

  task automatic test_random();
    logic [3:0][31:0] rk, k; logic v;
    int lat, bb; logic bd;
    for (int n = 0; n < 4; n++) begin
      rk = rand_key();
      model_expand(rk);
      run_schedule(rk, 0, '0, lat, bb, bd);
      n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required 11", n, lat); end
      for (int r = 0; r <= 10; r++) begin
        read_key(r, k, v);
        n_cmp++; if (k !== model_keys[r] || v !== 1'b1) begin n_fail++;
          $display("FAIL rand%0d_r%0d: got %h valid=%b required %h/1", n, r, k, v, model_keys[r]); end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_zero_key();
    test_fips();
    test_start_ignored();
    test_reset_mid();
    test_read_range();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
